// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) data-memory arbiter with round-robin tie-break and a
// read-modify-write sequencer that turns partial-byte writes into full-word writes.
module dmem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [3:0]  dma_be,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        mem_r_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;
    typedef enum logic {SRC_CPU, SRC_DMA} src_t;

    state_t      state_q, state_d;
    src_t        last_q, last_d;
    src_t        id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        cpu_rv_q, cpu_rv_d;
    logic        dma_rv_q, dma_rv_d;

    logic        cpu_win, dma_win, any_win;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr, sel_wdata;
    logic        sel_full, sel_none;
    logic [31:0] merged;

    // Arbitration: grants only in IDLE; on a tie the side not granted last wins.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (!reset && state_q == IDLE) begin
            if (cpu_req && (!dma_req || last_q == SRC_DMA)) begin
                cpu_win = 1'b1;
            end else if (dma_req) begin
                dma_win = 1'b1;
            end
        end
    end

    assign any_win   = cpu_win | dma_win;
    assign sel_we    = dma_win ? dma_we    : cpu_we;
    assign sel_be    = dma_win ? dma_be    : cpu_be;
    assign sel_addr  = dma_win ? dma_addr  : cpu_addr;
    assign sel_wdata = dma_win ? dma_wdata : cpu_wdata;
    assign sel_full  = (sel_be == 4'b1111);
    assign sel_none  = (sel_be == 4'b0000);

    always_comb begin
        merged = mem_out;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= SRC_DMA;
            id_q     <= SRC_CPU;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            cpu_rv_q <= 1'b0;
            dma_rv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            cpu_rv_q <= cpu_rv_d;
            dma_rv_q <= dma_rv_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        cpu_rv_d = 1'b0;
        dma_rv_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_win) begin
                    last_d = dma_win ? SRC_DMA : SRC_CPU;
                    if (!sel_we) begin
                        cpu_rv_d = cpu_win;
                        dma_rv_d = dma_win;
                    end else if (!sel_full && !sel_none) begin
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        be_d    = sel_be;
                        id_d    = dma_win ? SRC_DMA : SRC_CPU;
                        state_d = RMW_RD;
                    end
                end
            end
            RMW_RD: state_d = RMW_WR;
            RMW_WR: begin
                // RMW owner counts as last granted, so the other side wins the first IDLE tie
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cpu_gnt  = cpu_win;
        dma_gnt  = dma_win;
        mem_r_w  = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        busy     = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (any_win) begin
                        mem_addr = sel_addr;
                        if (sel_we && sel_full) begin
                            mem_r_w  = 1'b1;
                            mem_data = sel_wdata;
                        end
                    end
                end
                RMW_RD: begin
                    busy     = 1'b1;
                    mem_r_w  = 1'b1;
                    mem_addr = addr_q;
                    mem_data = merged;
                end
                RMW_WR: busy = 1'b1;
                default: busy = 1'b0;
            endcase
        end
    end

    assign cpu_rvalid = cpu_rv_q & ~reset;
    assign dma_rvalid = dma_rv_q & ~reset;
    assign cpu_rdata  = cpu_rvalid ? mem_out : '0;
    assign dma_rdata  = dma_rvalid ? mem_out : '0;

    a_single_gnt: assert property (@(posedge clk) !(cpu_gnt && dma_gnt));
    a_busy_state: assert property (@(posedge clk) disable iff (reset) busy == (state_q != IDLE));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level reference model with its own copy of memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [3:0]  cpu_be, dma_be;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_r_w, busy;
    logic [31:0] mem_addr, mem_data, mem_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_r_w(mem_r_w), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out),
        .busy(busy)
    );

    // 16-word synchronous memory attached to the DUT
    logic [31:0] init_img [16];
    logic [31:0] mem [16];
    logic        load_mem;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_img[i];
        end else if (mem_r_w) begin
            mem[mem_addr[5:2]] <= mem_data;
        end
        mem_out <= mem[mem_addr[5:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Reference model: memory image, last winner, remaining RMW cycles, pending read data
    logic [31:0] ref_mem [16];
    logic        r_last;
    int          r_left;
    logic [3:0]  r_idx, r_be;
    logic [31:0] r_wdata;
    logic        r_pc, r_pd;
    logic [31:0] r_pdc, r_pdd;
    logic        e_cg, e_dg, e_rw, e_busy, ck_addr, ck_data;
    logic [31:0] e_addr, e_data;
    logic        c_win, d_win, g_we;
    logic [3:0]  g_be;
    logic [31:0] g_addr, g_wdata;

    always @(negedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = init_img[i];
        end
        if (reset) begin
            check_eq("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
            check_eq("rst_dma_gnt",    32'(dma_gnt),    32'd0);
            check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            check_eq("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
            check_eq("rst_cpu_rdata",  cpu_rdata,       32'd0);
            check_eq("rst_dma_rdata",  dma_rdata,       32'd0);
            check_eq("rst_mem_r_w",    32'(mem_r_w),    32'd0);
            check_eq("rst_mem_addr",   mem_addr,        32'd0);
            check_eq("rst_mem_data",   mem_data,        32'd0);
            check_eq("rst_busy",       32'(busy),       32'd0);
            r_last = 1'b1;
            r_left = 0;
            r_pc   = 1'b0;
            r_pd   = 1'b0;
        end else begin
            e_cg = 1'b0; e_dg = 1'b0; e_rw = 1'b0;
            e_addr = '0; e_data = '0;
            ck_addr = 1'b1; ck_data = 1'b1;
            e_busy = (r_left != 0);
            check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(r_pc));
            check_eq("dma_rvalid", 32'(dma_rvalid), 32'(r_pd));
            check_eq("cpu_rdata",  cpu_rdata, r_pc ? r_pdc : 32'd0);
            check_eq("dma_rdata",  dma_rdata, r_pd ? r_pdd : 32'd0);
            r_pc = 1'b0;
            r_pd = 1'b0;
            if (r_left == 2) begin
                e_rw   = 1'b1;
                e_addr = {26'd0, r_idx, 2'b00};
                e_data = merge_bytes(ref_mem[r_idx], r_wdata, r_be);
                ref_mem[r_idx] = e_data;
                r_left = 1;
            end else if (r_left == 1) begin
                ck_addr = 1'b0;
                ck_data = 1'b0;
                r_left  = 0;
            end else begin
                c_win = cpu_req && (!dma_req || r_last);
                d_win = dma_req && !c_win;
                if (c_win || d_win) begin
                    g_we    = c_win ? cpu_we    : dma_we;
                    g_be    = c_win ? cpu_be    : dma_be;
                    g_addr  = c_win ? cpu_addr  : dma_addr;
                    g_wdata = c_win ? cpu_wdata : dma_wdata;
                    e_cg = c_win;
                    e_dg = d_win;
                    r_last  = d_win;
                    ck_data = 1'b0;
                    if (!g_we) begin
                        e_addr = g_addr;
                        r_pc = c_win;
                        r_pd = d_win;
                        if (c_win) r_pdc = ref_mem[g_addr[5:2]];
                        else       r_pdd = ref_mem[g_addr[5:2]];
                    end else if (g_be == 4'hF) begin
                        e_rw    = 1'b1;
                        e_addr  = g_addr;
                        e_data  = g_wdata;
                        ck_data = 1'b1;
                        ref_mem[g_addr[5:2]] = g_wdata;
                    end else if (g_be == 4'h0) begin
                        ck_addr = 1'b0;
                    end else begin
                        e_addr  = g_addr;
                        r_left  = 2;
                        r_idx   = g_addr[5:2];
                        r_wdata = g_wdata;
                        r_be    = g_be;
                    end
                end
            end
            check_eq("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
            check_eq("dma_gnt", 32'(dma_gnt), 32'(e_dg));
            check_eq("busy",    32'(busy),    32'(e_busy));
            check_eq("mem_r_w", 32'(mem_r_w), 32'(e_rw));
            if (ck_addr) check_eq("mem_addr", mem_addr, e_addr);
            if (ck_data) check_eq("mem_data", mem_data, e_data);
        end
    end

    task automatic set_cpu(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        dma_req = req; dma_we = we; dma_be = be; dma_addr = addr; dma_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_be();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 2)      return 4'h0;
        else if (r < 5) return 4'hF;
        else            return 4'($urandom);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) init_img[i] = $urandom;
        init_img[4] = 32'hDEADBEEF;
        init_img[8] = 32'h11223344;
        reset = 1'b1;
        load_mem = 1'b1;
        set_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        load_mem = 1'b0;
        reset = 1'b0;

        // Both sides read every cycle straight out of reset
        set_cpu(1'b1, 1'b0, 4'h0, 32'h10, 32'd0);
        set_dma(1'b1, 1'b0, 4'h0, 32'h20, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("tie_cpu_gnt", 32'(cpu_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("tie_dma_gnt", 32'(dma_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k == 1) begin
                check_eq("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
                check_eq("rd_cpu_rdata",  cpu_rdata,       32'hDEADBEEF);
                check_eq("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);
            end
            next_cycle();
        end
        set_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        next_cycle();

        // DMA partial write, CPU full write arriving mid-sequence
        set_dma(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        @(negedge clk);
        check_eq("pw_T_dma_gnt", 32'(dma_gnt), 32'd1);
        check_eq("pw_T_mem_r_w", 32'(mem_r_w), 32'd0);
        next_cycle();
        set_cpu(1'b1, 1'b1, 4'hF, 32'h30, 32'h55667788);
        @(negedge clk);
        check_eq("pw_T1_mem_r_w", 32'(mem_r_w), 32'd1);
        check_eq("pw_T1_mem_data", mem_data, 32'h11BB33DD);
        check_eq("pw_T1_busy", 32'(busy), 32'd1);
        check_eq("pw_T1_cpu_gnt", 32'(cpu_gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("pw_T2_mem_r_w", 32'(mem_r_w), 32'd0);
        check_eq("pw_T2_busy", 32'(busy), 32'd1);
        check_eq("pw_T2_cpu_gnt", 32'(cpu_gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("pw_T3_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check_eq("pw_T3_dma_gnt", 32'(dma_gnt), 32'd0);
        check_eq("pw_T3_mem_r_w", 32'(mem_r_w), 32'd1);
        next_cycle();
        set_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        check_eq("pw_word20", mem[8],  32'h11BB33DD);
        check_eq("pw_word30", mem[12], 32'h55667788);

        // Reset lands in RMW_RD of a CPU partial write
        next_cycle();
        set_cpu(1'b1, 1'b1, 4'b1100, 32'h20, 32'hFFFFFFFF);
        @(negedge clk);
        check_eq("ab_cpu_gnt", 32'(cpu_gnt), 32'd1);
        next_cycle();
        reset = 1'b1;
        set_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        check_eq("ab_rst_mem_r_w", 32'(mem_r_w), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("ab_post_mem_r_w", 32'(mem_r_w), 32'd0);
        check_eq("ab_post_busy", 32'(busy), 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("ab_word20", mem[8], 32'h11BB33DD);

        // Empty byte-enable write is a granted no-op
        next_cycle();
        set_cpu(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        check_eq("nop_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check_eq("nop_mem_r_w", 32'(mem_r_w), 32'd0);
        next_cycle();
        set_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        check_eq("nop_word10", mem[4], 32'hDEADBEEF);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            reset = ($urandom_range(0, 63) == 0);
            set_cpu(1'($urandom), 1'($urandom), rand_be(),
                    {26'd0, 4'($urandom), 2'b00}, $urandom);
            set_dma(1'($urandom), 1'($urandom), rand_be(),
                    {26'd0, 4'($urandom), 2'b00}, $urandom);
        end
        next_cycle();
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        repeat (4) next_cycle();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("final_word%0d", i), mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
